// File: rtl/cmd_seq_rx_core.sv
// Receive side of the command sequencer: hunts for a sync word on a 2x-oversampled
// serial line (NRZ or Manchester), then deserialises the payload MSB-first into a FWFT byte FIFO.
module cmd_seq_rx_core #(
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RX_ENABLE,
  input  logic [1:0]  CONF_MODE,
  input  logic [7:0]  CONF_SYNC,
  input  logic [15:0] CONF_BIT_COUNT,
  input  logic        CMD_DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_VALID,
  input  logic        DATA_READY,
  output logic        FRAME_DONE,
  output logic        CODE_ERR,
  output logic        OVERFLOW,
  output logic        BUSY
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  state_t                   r_state, w_state_next;
  logic                     r_meta, r_sync;
  logic [15:0]              r_hs;
  logic [1:0]               r_mode;
  logic [15:0]              r_count;
  logic [15:0]              r_bit_cnt;
  logic                     r_phase;
  logic [7:0]               r_byte;
  logic                     r_frame_done, r_code_err, r_overflow;
  logic [FIFO_ADDR_WIDTH:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]               r_mem [DEPTH];

  logic [15:0] w_sync_exp;
  logic        w_match, w_decode, w_bit, w_bad, w_last, w_full_byte;
  logic [15:0] w_bit_cnt_inc;
  logic [7:0]  w_byte_shift;
  logic [2:0]  w_pad;
  logic        w_push, w_frame_done_next, w_code_err_next;
  logic [7:0]  w_push_data;
  logic        w_pop, w_full, w_wr_en;

  // Each sync bit becomes an (older, newer) half-sample pair; older sits at the higher index.
  function automatic logic [15:0] expand_sync(input logic [1:0] mode, input logic [7:0] sync);
    logic [15:0] exp_v;
    exp_v = '0;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        2'd2:    exp_v[2*i +: 2] = {~sync[i], sync[i]};
        2'd3:    exp_v[2*i +: 2] = {sync[i], ~sync[i]};
        default: exp_v[2*i +: 2] = {sync[i], sync[i]};
      endcase
    end
    return exp_v;
  endfunction

  assign w_sync_exp    = expand_sync(CONF_MODE, CONF_SYNC);
  assign w_match       = RX_ENABLE && (r_state == ST_HUNT) && (r_hs == w_sync_exp);
  assign w_decode      = RX_ENABLE && (r_state == ST_RECV) && r_phase;
  assign w_bit         = (r_mode == 2'd3) ? r_hs[1] : r_hs[0];
  assign w_bad         = r_mode[1] && (r_hs[1] == r_hs[0]);
  assign w_bit_cnt_inc = r_bit_cnt + 16'd1;
  assign w_byte_shift  = {r_byte[6:0], w_bit};
  assign w_last        = (w_bit_cnt_inc == r_count);
  assign w_full_byte   = (w_bit_cnt_inc[2:0] == 3'd0);
  assign w_pad         = 3'd0 - w_bit_cnt_inc[2:0];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next      = r_state;
    w_push            = 1'b0;
    w_push_data       = w_byte_shift;
    w_frame_done_next = 1'b0;
    w_code_err_next   = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_match) begin
          if (CONF_BIT_COUNT == 16'd0) w_frame_done_next = 1'b1;
          else                         w_state_next      = ST_RECV;
        end
      end
      ST_RECV: begin
        if (!RX_ENABLE) begin
          w_state_next = ST_HUNT;
        end else if (w_decode) begin
          if (w_bad) begin
            w_code_err_next = 1'b1;
            w_state_next    = ST_HUNT;
          end else begin
            if (w_full_byte) begin
              w_push = 1'b1;
            end else if (w_last) begin
              // Trailing partial byte is left-aligned, zero-padded in the LSBs.
              w_push      = 1'b1;
              w_push_data = w_byte_shift << w_pad;
            end
            if (w_last) begin
              w_frame_done_next = 1'b1;
              w_state_next      = ST_HUNT;
            end
          end
        end
      end
      default: w_state_next = ST_HUNT;
    endcase
  end

  assign DATA_VALID = (r_wr_ptr != r_rd_ptr);
  assign w_pop      = DATA_VALID && DATA_READY;
  assign w_full     = (r_wr_ptr[FIFO_ADDR_WIDTH] != r_rd_ptr[FIFO_ADDR_WIDTH]) &&
                      (r_wr_ptr[FIFO_ADDR_WIDTH-1:0] == r_rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign w_wr_en    = w_push && (!w_full || w_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_HUNT;
      r_meta       <= 1'b0;
      r_sync       <= 1'b0;
      r_hs         <= '0;
      r_mode       <= '0;
      r_count      <= '0;
      r_bit_cnt    <= '0;
      r_phase      <= 1'b0;
      r_byte       <= '0;
      r_frame_done <= 1'b0;
      r_code_err   <= 1'b0;
      r_overflow   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_state      <= w_state_next;
      r_meta       <= CMD_DATA_IN;
      r_sync       <= r_meta;
      r_hs         <= {r_hs[14:0], r_sync};
      // Phase is cleared in HUNT so the first decode lands two cycles after the match.
      r_phase      <= (r_state == ST_HUNT) ? 1'b0 : ~r_phase;
      r_frame_done <= w_frame_done_next;
      r_code_err   <= w_code_err_next;
      if (w_match) begin
        r_mode    <= CONF_MODE;
        r_count   <= CONF_BIT_COUNT;
        r_bit_cnt <= '0;
        r_byte    <= '0;
      end else if (w_decode) begin
        r_bit_cnt <= w_bit_cnt_inc;
        r_byte    <= w_byte_shift;
      end
      if (!RX_ENABLE)                r_overflow <= 1'b0;
      else if (w_push && !w_wr_en)   r_overflow <= 1'b1;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers define emptiness and DATA_OUT is gated below.
  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= w_push_data;
  end

  assign DATA_OUT   = DATA_VALID ? r_mem[r_rd_ptr[FIFO_ADDR_WIDTH-1:0]] : 8'h00;
  assign FRAME_DONE = r_frame_done;
  assign CODE_ERR   = r_code_err;
  assign OVERFLOW   = r_overflow;
  assign BUSY       = (r_state == ST_RECV);

endmodule
